gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
Parametrised up/down counter that keeps a binary count and its Gray-code form in registers, both updated on the same clock edge. Replaces stand-alone combinational binary-to-Gray conversion wherever a Gray-sequenced count is needed (pointer generation, low-toggle address sequencing, position encoders). Supports binary or Gray parallel load, wrap or saturate mode, and a wrap event pulse.

Parameters:
WIDTH, 4, counter width in bits (>= 2)
RESET_VAL, 0, binary count value loaded on reset (must fit in WIDTH)
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; one step per cycle while high
up_dn  input  1  1 = count up, 0 = count down; sampled only when en=1
load  input  1  synchronous parallel load; overrides en
load_is_gray  input  1  1 = load_val is Gray-coded, 0 = load_val is binary
load_val  input  WIDTH  parallel load value
count_bin  output  WIDTH  registered binary count
count_gray  output  WIDTH  registered Gray count, always equal to count_bin ^ (count_bin >> 1)
wrap  output  1  registered one-cycle pulse on a wrap event
at_max  output  1  high while count_bin is all ones
at_min  output  1  high while count_bin is all zeros

Behaviour:
- Reset (rst_n low, async, effective immediately, also mid-count): count_bin = RESET_VAL, count_gray = gray(RESET_VAL), wrap = 0. Outputs hold these values until the first rising edge after rst_n rises.
- Priority per rising edge: load > en > hold.
- Load: next_bin = load_val if load_is_gray = 0. Otherwise next_bin = Gray-to-binary of load_val (bit WIDTH-1 copied; bit i = bit i+1 of result XOR load_val[i]). wrap = 0 on a load cycle. en and up_dn are ignored.
- Count (en=1, load=0): up gives next_bin = count_bin + 1, down gives next_bin = count_bin - 1, both modulo 2^WIDTH.
- Wrap mode (SATURATE=0):
  - up at all ones gives 0 with wrap = 1 on the next cycle.
  - down at 0 gives all ones with wrap = 1.
- Saturate mode (SATURATE=1):
  - up at all ones holds; down at 0 holds.
  - wrap stays 0 permanently.
- Hold (en=0, load=0): count unchanged; wrap = 0.
- count_gray is registered from next_bin in the same edge as count_bin. No cycle where the two disagree.
- Latency: one cycle from load or en to updated outputs.
- On every counting step, count_gray changes in exactly one bit. On a saturated hold, zero bits change. Loads may change any number of bits.
- at_max and at_min are decoded combinationally from the count_bin register only (no input paths).
- up_dn may change on any cycle, including directly at a limit. The direction applied is the one sampled on that edge.

Test Plan:
- Reset, WIDTH=4, RESET_VAL=5: assert rst_n=0 mid-cycle -> count_bin=0101 and count_gray=0111 immediately, wrap=0; release, en=0 -> values held.
- Up sweep, SATURATE=0: from 0, en=1, up_dn=1 for 17 cycles -> count_gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. wrap pulses for one cycle on the 1111->0000 step. at_max is high only at count 15. Check a single-bit Gray change on every step.
- Down wrap: count 0, en=1, up_dn=0 -> count_bin=1111, count_gray=1000, wrap=1 for one cycle. Next step gives 1110 with wrap=0.
- Gray load: load=1, load_is_gray=1, load_val=1101, en=1 -> count_bin=1001 and count_gray=1101 (load wins over en). Binary load of 0110 -> count_gray=0101.
- Saturate, SATURATE=1: count at 1110, up for 3 cycles -> 1111, 1111, 1111, wrap never asserted. Then down from 0001 for 3 cycles -> 0000, 0000, 0000.
- Direction flip and reset during count: en=1 with up_dn toggling every cycle from 7 -> 8,7,8,7. Assert rst_n=0 during the sequence -> RESET_VAL immediately. Counting resumes from RESET_VAL after release.

Source files
------------

// File: rtl/gray_code_counter.sv
// Up/down counter holding both binary and Gray forms of the count in registers,
// with binary or Gray parallel load, wrap/saturate limit handling and a wrap pulse.
module gray_code_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // MSB passes straight through; each lower bit folds in the decoded bit above it.
  function automatic logic [WIDTH-1:0] from_gray(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    r[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;

  always_comb begin
    next_bin  = count_bin;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = load_is_gray ? from_gray(load_val) : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (count_bin == ALL_ONES) begin
          if (!SATURATE) begin
            next_bin  = ALL_ZERO;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = count_bin + ONE;
        end
      end else begin
        if (count_bin == ALL_ZERO) begin
          if (!SATURATE) begin
            next_bin  = ALL_ONES;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = count_bin - ONE;
        end
      end
    end
  end

  // Both forms load from next_bin on the same edge so they can never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_bin  <= RESET_VAL;
      count_gray <= to_gray(RESET_VAL);
      wrap       <= 1'b0;
    end else begin
      count_bin  <= next_bin;
      count_gray <= to_gray(next_bin);
      wrap       <= next_wrap;
    end
  end

  assign at_max = (count_bin == ALL_ONES);
  assign at_min = (count_bin == ALL_ZERO);

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: a wrapping and a saturating instance share stimulus;
// hand-computed expectations go through a queue checked by an independent monitor.
module tb_gray_code_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic       load_is_gray;
  logic [3:0] load_val;

  logic [3:0] bin_a, gray_a, bin_b, gray_b;
  logic       wrap_a, max_a, min_a, wrap_b, max_b, min_b;

  // Expectation word per instance: {bin[3:0], gray[3:0], wrap, flips[1:0]}
  // flips: 0 = no Gray bit may change, 1 = exactly one, 2 = not checked.
  localparam int EW = 22;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic [3:0]    prev_a, prev_b;

  int n_checks;
  int n_pass;

  gray_code_counter #(.WIDTH(4), .RESET_VAL(4'd5), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .count_bin(bin_a), .count_gray(gray_a), .wrap(wrap_a),
    .at_max(max_a), .at_min(min_a)
  );

  gray_code_counter #(.WIDTH(4), .RESET_VAL(4'd5), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .count_bin(bin_b), .count_gray(gray_b), .wrap(wrap_b),
    .at_max(max_b), .at_min(min_b)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
  endtask

  task automatic check_inst(input string tag, input logic [3:0] bin, input logic [3:0] gray,
                            input logic wr, input logic mx, input logic mn,
                            input logic [3:0] prev, input logic [10:0] x);
    chk({tag, "_bin"},    32'(bin),  32'(x[10:7]));
    chk({tag, "_gray"},   32'(gray), 32'(x[6:3]));
    chk({tag, "_wrap"},   32'(wr),   32'(x[2]));
    chk({tag, "_at_max"}, 32'(mx),   32'(x[10:7] == 4'hF));
    chk({tag, "_at_min"}, 32'(mn),   32'(x[10:7] == 4'h0));
    if (x[1:0] != 2'd2) chk({tag, "_gray_flips"}, 32'($countones(prev ^ gray)), 32'(x[1:0]));
  endtask

  function automatic logic [10:0] pk(input logic [3:0] b, input logic [3:0] g,
                                     input logic w, input logic [1:0] f);
    return {b, g, w, f};
  endfunction

  // driver: apply one cycle of inputs and queue what each instance must show after the edge
  task automatic step(input logic s_en, input logic s_up, input logic s_load,
                      input logic s_lig, input logic [3:0] s_val,
                      input logic [10:0] ea, input logic [10:0] eb);
    @(negedge clk);
    en = s_en; up_dn = s_up; load = s_load; load_is_gray = s_lig; load_val = s_val;
    exp_q.push_back({ea, eb});
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, "_a_bin"},  32'(bin_a),  32'h5);
    chk({tag, "_a_gray"}, 32'(gray_a), 32'h7);
    chk({tag, "_a_wrap"}, 32'(wrap_a), 32'h0);
    chk({tag, "_b_bin"},  32'(bin_b),  32'h5);
    chk({tag, "_b_gray"}, 32'(gray_b), 32'h7);
    chk({tag, "_b_wrap"}, 32'(wrap_b), 32'h0);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_inst("wrapmode", bin_a, gray_a, wrap_a, max_a, min_a, prev_a, e[21:11]);
      check_inst("satmode",  bin_b, gray_b, wrap_b, max_b, min_b, prev_b, e[10:0]);
    end
    prev_a = gray_a;
    prev_b = gray_b;
  end

  initial begin
    logic [3:0] gray_tab [16];
    logic [3:0] ba, bb;
    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    n_checks = 0; n_pass = 0;
    rst_n = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_is_gray = 1'b0; load_val = '0;

    // asynchronous reset asserted mid-cycle, then released and held
    #7 rst_n = 1'b0;
    #1 check_reset_now("reset_immediate");
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0, 0, 4'h0, pk(4'h5, 4'b0111, 0, 0), pk(4'h5, 4'b0111, 0, 0));
    step(0, 1, 0, 0, 4'h0, pk(4'h5, 4'b0111, 0, 0), pk(4'h5, 4'b0111, 0, 0));

    // up sweep from 0 across the top
    step(0, 0, 1, 0, 4'h0, pk(4'h0, 4'h0, 0, 2), pk(4'h0, 4'h0, 0, 2));
    for (int i = 1; i <= 16; i++) begin
      ba = 4'(i);
      bb = (i == 16) ? 4'hF : 4'(i);
      step(1, 1, 0, 0, 4'h0,
           pk(ba, gray_tab[ba], (i == 16), 2'd1),
           pk(bb, gray_tab[bb], 1'b0, (i == 16) ? 2'd0 : 2'd1));
    end

    // down across zero
    step(0, 0, 1, 0, 4'h0, pk(4'h0, 4'h0, 0, 2), pk(4'h0, 4'h0, 0, 2));
    step(1, 0, 0, 0, 4'h0, pk(4'hF, 4'b1000, 1, 1), pk(4'h0, 4'h0, 0, 0));
    step(1, 0, 0, 0, 4'h0, pk(4'hE, 4'b1001, 0, 1), pk(4'h0, 4'h0, 0, 0));

    // Gray load wins over en, then binary load
    step(1, 1, 1, 1, 4'b1101, pk(4'b1001, 4'b1101, 0, 2), pk(4'b1001, 4'b1101, 0, 2));
    step(1, 0, 1, 0, 4'b0110, pk(4'b0110, 4'b0101, 0, 2), pk(4'b0110, 4'b0101, 0, 2));

    // top limit: wrap instance rolls over, saturating instance holds
    step(0, 0, 1, 0, 4'hE, pk(4'hE, 4'b1001, 0, 2), pk(4'hE, 4'b1001, 0, 2));
    step(1, 1, 0, 0, 4'h0, pk(4'hF, 4'b1000, 0, 1), pk(4'hF, 4'b1000, 0, 1));
    step(1, 1, 0, 0, 4'h0, pk(4'h0, 4'b0000, 1, 1), pk(4'hF, 4'b1000, 0, 0));
    step(1, 1, 0, 0, 4'h0, pk(4'h1, 4'b0001, 0, 1), pk(4'hF, 4'b1000, 0, 0));

    // bottom limit
    step(0, 0, 1, 0, 4'h1, pk(4'h1, 4'b0001, 0, 2), pk(4'h1, 4'b0001, 0, 2));
    step(1, 0, 0, 0, 4'h0, pk(4'h0, 4'b0000, 0, 1), pk(4'h0, 4'b0000, 0, 1));
    step(1, 0, 0, 0, 4'h0, pk(4'hF, 4'b1000, 1, 1), pk(4'h0, 4'b0000, 0, 0));
    step(1, 0, 0, 0, 4'h0, pk(4'hE, 4'b1001, 0, 1), pk(4'h0, 4'b0000, 0, 0));

    // direction flip every cycle from 7
    step(0, 0, 1, 0, 4'h7, pk(4'h7, 4'b0100, 0, 2), pk(4'h7, 4'b0100, 0, 2));
    step(1, 1, 0, 0, 4'h0, pk(4'h8, 4'b1100, 0, 1), pk(4'h8, 4'b1100, 0, 1));
    step(1, 0, 0, 0, 4'h0, pk(4'h7, 4'b0100, 0, 1), pk(4'h7, 4'b0100, 0, 1));
    step(1, 1, 0, 0, 4'h0, pk(4'h8, 4'b1100, 0, 1), pk(4'h8, 4'b1100, 0, 1));
    step(1, 0, 0, 0, 4'h0, pk(4'h7, 4'b0100, 0, 1), pk(4'h7, 4'b0100, 0, 1));
    drain();

    // reset while still counting
    @(negedge clk); en = 1'b1; up_dn = 1'b1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_reset_now("reset_mid_count");
    @(posedge clk); #1 check_reset_now("reset_held_over_edge");
    @(negedge clk); rst_n = 1'b1; en = 1'b0;
    step(0, 1, 0, 0, 4'h0, pk(4'h5, 4'b0111, 0, 0), pk(4'h5, 4'b0111, 0, 0));
    step(1, 1, 0, 0, 4'h0, pk(4'h6, 4'b0101, 0, 1), pk(4'h6, 4'b0101, 0, 1));
    step(1, 1, 0, 0, 4'h0, pk(4'h7, 4'b0100, 0, 1), pk(4'h7, 4'b0100, 0, 1));
    step(0, 0, 0, 0, 4'h0, pk(4'h7, 4'b0100, 0, 0), pk(4'h7, 4'b0100, 0, 0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
